// File: rtl/cordic_pkg.sv
// Shared float/fixed definitions for the CORDIC datapath and its float
// converters on the input and output sides.
package cordic_pkg;

    localparam int FLOAT_EXP_BIAS = 127;
    localparam int FLOAT_MANT_W   = 23;
    localparam int FLOAT_EXP_W    = 8;

    typedef struct packed {
        logic                    sign;
        logic [FLOAT_EXP_W-1:0]  exp;
        logic [FLOAT_MANT_W-1:0] frac;
    } float_t;

    typedef enum logic [1:0] {
        FC_ZERO,
        FC_NORM,
        FC_INF,
        FC_NAN
    } float_class_t;

    // Denormals fold into FC_ZERO: their value is far below one fixed LSB.
    function automatic float_class_t float_classify(input float_t f);
        float_class_t c;
        if (f.exp == '0)
            c = FC_ZERO;
        else if (f.exp == '1)
            c = (f.frac != '0) ? FC_NAN : FC_INF;
        else
            c = FC_NORM;
        return c;
    endfunction

endpackage

// File: rtl/fixed_align_shift.sv
// Bidirectional barrel shifter that places a 24-bit float mantissa onto a
// fixed-point grid and flags results that do not fit a signed WIDTH word.
module fixed_align_shift #(
    parameter int WIDTH = 23
) (
    input  logic [23:0]       m24,
    input  logic signed [9:0] sh,
    input  logic              neg,
    output logic [WIDTH-1:0]  mag,
    output logic              ovf
);

    // The wide field holds the largest left shift (clamped to WIDTH) without
    // losing bits, so the overflow compare sees the true magnitude.
    localparam int FW = WIDTH + 24;
    localparam logic [FW-1:0] NEG_LIM = FW'(1) << (WIDTH - 1);
    localparam logic [FW-1:0] POS_LIM = NEG_LIM - FW'(1);

    logic [FW-1:0] ext;
    logic [FW-1:0] wide;
    logic [9:0]    nsh;
    logic          clamped;

    // Shift left for sh >= 0 (clamped), right with truncation for sh < 0.
    always_comb begin
        ext     = FW'(m24);
        wide    = '0;
        nsh     = '0;
        clamped = 1'b0;
        if (!sh[9]) begin
            if ($unsigned(sh) > 10'(WIDTH)) begin
                clamped = 1'b1;
                wide    = ext << WIDTH;
            end else begin
                wide = ext << $unsigned(sh);
            end
        end else begin
            nsh = 10'(-sh);
            if (nsh >= 10'd24)
                wide = '0;
            else
                wide = ext >> nsh;
        end
        // Negative side admits one extra step: -2^(WIDTH-1) is representable.
        ovf = (clamped && (m24 != '0)) || (wide > (neg ? NEG_LIM : POS_LIM));
        mag = wide[WIDTH-1:0];
    end

endmodule

// File: rtl/float_to_fixed_pipe.sv
// Three-stage IEEE-754 single to signed Q(INTS.FRACS) converter with
// saturation, NaN/Inf flags and a global clock enable.
module float_to_fixed_pipe
    import cordic_pkg::*;
#(
    parameter int INTS  = 1,
    parameter int FRACS = 21,
    parameter int WIDTH = 1 + INTS + FRACS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic             in_valid,
    input  logic [31:0]      floatIn,
    output logic             out_valid,
    output logic [WIDTH-1:0] fixedOut,
    output logic             ovf,
    output logic             nan
);

    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    float_t       f_in;
    logic [2:0]   vld_pipe;

    // stage 1 state
    logic         s1;
    logic [7:0]   e1;
    logic [23:0]  m1;
    float_class_t cls1;

    // stage 2 state
    logic             s2;
    float_class_t     cls2;
    logic [WIDTH-1:0] mag2;
    logic             ovf2;

    logic signed [9:0] sh;
    logic [WIDTH-1:0]  sh_mag;
    logic              sh_ovf;

    assign f_in      = float_t'(floatIn);
    assign out_valid = vld_pipe[2];

    // Valid tags advance with the data; reset drops anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_pipe <= '0;
        else if (clk_en)
            vld_pipe <= {vld_pipe[1:0], in_valid};
    end

    // Stage 1: unpack fields, restore the hidden bit, classify.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            e1   <= '0;
            m1   <= '0;
            cls1 <= FC_ZERO;
        end else if (clk_en && in_valid) begin
            s1   <= f_in.sign;
            e1   <= f_in.exp;
            m1   <= {f_in.exp != '0, f_in.frac};
            cls1 <= float_classify(f_in);
        end
    end

    // Distance from mantissa LSB weight (2^(e-150)) to fixed LSB weight (2^-FRACS).
    always_comb begin
        sh = 10'(e1) - 10'(FLOAT_EXP_BIAS + FLOAT_MANT_W) + 10'(FRACS);
    end

    fixed_align_shift #(.WIDTH(WIDTH)) u_align (
        .m24 (m1),
        .sh  (sh),
        .neg (s1),
        .mag (sh_mag),
        .ovf (sh_ovf)
    );

    // Stage 2: register aligned magnitude; only normals carry a magnitude.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2   <= 1'b0;
            cls2 <= FC_ZERO;
            mag2 <= '0;
            ovf2 <= 1'b0;
        end else if (clk_en && vld_pipe[0]) begin
            s2   <= s1;
            cls2 <= cls1;
            mag2 <= (cls1 == FC_NORM) ? sh_mag : '0;
            ovf2 <= (cls1 == FC_NORM) && sh_ovf;
        end
    end

    // Stage 3: apply sign, saturate, raise flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fixedOut <= '0;
            ovf      <= 1'b0;
            nan      <= 1'b0;
        end else if (clk_en && vld_pipe[1]) begin
            if (cls2 == FC_NAN) begin
                fixedOut <= '0;
                ovf      <= 1'b0;
                nan      <= 1'b1;
            end else if (cls2 == FC_INF || ovf2) begin
                fixedOut <= s2 ? SAT_NEG : SAT_POS;
                ovf      <= 1'b1;
                nan      <= 1'b0;
            end else begin
                // -0 and -denormal arrive with mag2 == 0, so negation yields 0.
                fixedOut <= s2 ? (WIDTH'(0) - mag2) : mag2;
                ovf      <= 1'b0;
                nan      <= 1'b0;
            end
        end
    end

endmodule
